// File: rtl/vga_line_fetch.sv
// vga_line_fetch: per-line SPRAM row fetch into a line buffer, streamed out as RGB565 inside the image window
module vga_line_fetch #(
  parameter int          W        = 200,
  parameter int          H        = 150,
  parameter int          STARTROW = 0,
  parameter int          STARTCOL = 0,
  parameter int          RD_LAT   = 1,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  state,
  input  logic        spram_rd_sig,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [15:0] spram_dout,
  output logic [14:0] spram_addr,
  output logic        spram_rden,
  output logic        fetch_busy,
  output logic        pix_valid,
  output logic [15:0] pix_rgb,
  output logic        err_overrun,
  output logic        err_underrun
);
  localparam int CW = $clog2(W);
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} fsm_t;
  fsm_t          r_fsm;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [1:0]    r_dcnt;
  logic [14:0]   r_addr;
  logic          r_rden, r_busy, r_ovr, r_und;
  logic          r_pv   [RD_LAT];
  logic [CW-1:0] r_pidx [RD_LAT];
  logic [15:0]   r_buf  [W];
  logic [15:0]   r_rd, r_pix;
  logic          r_win1, r_pvalid;
  logic          w_active, w_in_win;
  logic [11:0]   w_bx, w_by;
  logic [CW-1:0] w_rd_idx;
  logic [14:0]   w_base;
  assign w_active   = state == 8'h03;
  assign w_bx       = xpos - 12'(STARTCOL);
  assign w_by       = ypos - 12'(STARTROW);
  assign w_in_win   = (w_bx < 12'(W)) && (w_by < 12'(H));
  assign w_rd_idx   = (w_bx < 12'(W)) ? w_bx[CW-1:0] : '0;
  assign w_base     = 15'(int'(r_row) * W);
  assign spram_addr   = r_addr;
  assign spram_rden   = r_rden;
  assign fetch_busy   = r_busy;
  assign err_overrun  = r_ovr;
  assign err_underrun = r_und;
  assign pix_valid    = r_pvalid;
  assign pix_rgb      = r_pix;
  // fetch sequencer: issue W row addresses, wait out the read latency, advance the row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm  <= S_IDLE;
      r_row  <= '0;
      r_col  <= '0;
      r_dcnt <= '0;
      r_addr <= '0;
      r_rden <= 1'b0;
      r_busy <= 1'b0;
      r_ovr  <= 1'b0;
      r_und  <= 1'b0;
    end else if (!w_active) begin
      r_fsm  <= S_IDLE;
      r_row  <= '0;
      r_col  <= '0;
      r_dcnt <= '0;
      r_rden <= 1'b0;
      r_busy <= 1'b0;
      r_ovr  <= 1'b0;
      r_und  <= 1'b0;
    end else begin
      if (spram_rd_sig && r_busy) r_ovr <= 1'b1;
      if (w_in_win && xpos == 12'(STARTCOL) && r_busy) r_und <= 1'b1;
      case (r_fsm)
        S_IDLE:
          if (spram_rd_sig) begin
            r_fsm  <= S_FETCH;
            r_rden <= 1'b1;
            r_busy <= 1'b1;
            r_col  <= '0;
            r_addr <= w_base;
          end
        S_FETCH:
          if (r_col == CW'(W - 1)) begin
            r_fsm  <= S_DRAIN;
            r_rden <= 1'b0;
            r_dcnt <= 2'(RD_LAT - 1);
          end else begin
            r_col  <= r_col + 1'b1;
            r_addr <= r_addr + 15'd1;
          end
        S_DRAIN:
          if (r_dcnt == '0) begin
            r_fsm  <= S_IDLE;
            r_busy <= 1'b0;
            r_row  <= (r_row == RW'(H - 1)) ? '0 : r_row + 1'b1;
          end else begin
            r_dcnt <= r_dcnt - 2'd1;
          end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end
  // valid/index delay line so each word lands in the buffer RD_LAT cycles after its address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i]   <= 1'b0;
        r_pidx[i] <= '0;
      end
    end else begin
      r_pv[0]   <= w_active && r_rden;
      r_pidx[0] <= r_col;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]   <= w_active && r_pv[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
    end
  end
  // dual-port line buffer; a same-cycle read sees the previous contents
  always_ff @(posedge clk) begin
    if (r_pv[RD_LAT-1]) r_buf[r_pidx[RD_LAT-1]] <= spram_dout;
    r_rd <= r_buf[w_rd_idx];
  end
  // two-stage pixel output: window flag follows the buffer read, background outside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win1   <= 1'b0;
      r_pvalid <= 1'b0;
      r_pix    <= BG_COLOR;
    end else if (!w_active) begin
      r_win1   <= 1'b0;
      r_pvalid <= 1'b0;
      r_pix    <= BG_COLOR;
    end else begin
      r_win1   <= w_in_win;
      r_pvalid <= r_win1;
      r_pix    <= r_win1 ? r_rd : BG_COLOR;
    end
  end
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: randomized scoreboard bench for the line fetcher against an SPRAM and image model
module tb_vga_line_fetch;
  localparam int          W  = 200;
  localparam int          H  = 150;
  localparam int          SR = 0;
  localparam int          SC = 0;
  localparam int          RL = 1;
  localparam logic [15:0] BG = 16'h0000;
  logic        clk = 1'b0, rst_n = 1'b0, rd_sig = 1'b0;
  logic [7:0]  state = 8'h03;
  logic [11:0] xpos = 12'hFFF, ypos = 12'hFFF;
  logic [15:0] dout;
  logic [14:0] o_addr;
  logic        o_rden, o_busy, o_pvalid, o_ovr, o_und;
  logic [15:0] o_rgb;
  vga_line_fetch dut (
    .clk(clk), .rst_n(rst_n), .state(state), .spram_rd_sig(rd_sig),
    .xpos(xpos), .ypos(ypos), .spram_dout(dout),
    .spram_addr(o_addr), .spram_rden(o_rden), .fetch_busy(o_busy),
    .pix_valid(o_pvalid), .pix_rgb(o_rgb),
    .err_overrun(o_ovr), .err_underrun(o_und)
  );
  always #5 clk = ~clk;
  typedef struct {int due; bit dc; bit v; logic [15:0] rgb;} px_t;
  px_t         pxq[$];
  px_t         pp;
  logic [14:0] aq[$];
  logic [14:0] ea;
  logic [15:0] key;
  logic [15:0] dpipe [RL];
  int tests = 0, fails = 0, cyc = 0;
  int row_m = 0, buf_row = -1;
  bit ovr_m = 0, und_m = 0;
  function automatic logic [15:0] img(int a);
    return 16'(a) ^ key;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    dpipe[0] <= o_rden ? img(int'(o_addr)) : 16'hDEAD;
    for (int k = 1; k < RL; k++) dpipe[k] <= dpipe[k-1];
  end
  assign dout = dpipe[RL-1];
  always @(negedge clk) if (rst_n) begin
    if (o_rden) begin
      if (aq.size() == 0) chk("spurious_rden", 32'(o_addr), 32'h7FFF_FFFF);
      else begin
        ea = aq.pop_front();
        chk("spram_addr", 32'(o_addr), 32'(ea));
      end
    end
    if (pxq.size() > 0 && pxq[0].due < cyc) begin
      chk("pix_missed", 32'(cyc), 32'(pxq[0].due));
      pp = pxq.pop_front();
    end else if (pxq.size() > 0 && pxq[0].due == cyc) begin
      pp = pxq.pop_front();
      chk("pix_valid", 32'(o_pvalid), 32'(pp.v));
      if (!pp.dc) chk("pix_rgb", 32'(o_rgb), 32'(pp.rgb));
    end else if (pxq.size() == 0) begin
      chk("idle_valid", 32'(o_pvalid), 32'd0);
      chk("idle_rgb", 32'(o_rgb), 32'(BG));
    end
  end
  task automatic drive_px(logic [11:0] x, logic [11:0] y, bit dc);
    logic [11:0] dx, dy;
    bit v;
    dx = x - 12'(SC);
    dy = y - 12'(SR);
    v = (dx < 12'(W)) && (dy < 12'(H));
    xpos = x;
    ypos = y;
    pxq.push_back('{cyc + 2, dc, v, v ? img(buf_row * W + int'(dx)) : BG});
  endtask
  task automatic px_phase(int len, bit sweep);
    for (int i = 0; i < len; i++) begin
      if (sweep) drive_px(12'(i + SC), 12'(SR), 1'b0);
      else drive_px(($urandom_range(0, 7) == 0) ? 12'hFF0 + 12'($urandom_range(0, 15)) : 12'(SC + $urandom_range(0, W + 15)),
                    ($urandom_range(0, 9) == 0) ? 12'hFFE : 12'(SR + $urandom_range(0, H + 3)), 1'b0);
      @(posedge clk); #1;
    end
    xpos = 12'hFFF;
    ypos = 12'hFFF;
  endtask
  task automatic fetch(int ovr_at, int und_at);
    int n;
    rd_sig = 1'b1;
    for (int c = 0; c < W; c++) aq.push_back(15'(row_m * W + c));
    @(posedge clk); #1;
    rd_sig = 1'b0;
    n = 0;
    while (o_busy && n < W + RL + 20) begin
      n++;
      if (n == ovr_at) begin rd_sig = 1'b1; ovr_m = 1; end
      if (n == und_at) begin drive_px(12'(SC), 12'(SR), 1'b1); und_m = 1; end
      if (n == und_at + 1) drive_px(12'hFFF, 12'hFFF, 1'b0);
      @(posedge clk); #1;
      rd_sig = 1'b0;
    end
    chk("busy_len", 32'(n), 32'(W + RL));
    chk("addr_drained", 32'(aq.size()), 32'd0);
    chk("err_overrun", 32'(o_ovr), 32'(ovr_m));
    chk("err_underrun", 32'(o_und), 32'(und_m));
    aq.delete();
    buf_row = row_m;
    row_m = (row_m + 1) % H;
  endtask
  task automatic chk_reset_vals(string tag);
    chk({tag, "_rden"}, 32'(o_rden), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_addr"}, 32'(o_addr), 32'd0);
    chk({tag, "_pvalid"}, 32'(o_pvalid), 32'd0);
    chk({tag, "_rgb"}, 32'(o_rgb), 32'(BG));
    chk({tag, "_ovr"}, 32'(o_ovr), 32'd0);
    chk({tag, "_und"}, 32'(o_und), 32'd0);
  endtask
  initial begin
    key = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fetch(-1, -1);
    px_phase(W + 1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    px_phase(300, 1'b0);
    for (int i = 1; i <= H; i++) begin
      fetch(-1, -1);
      repeat ($urandom_range(3, 20)) @(posedge clk);
      #1;
      if (i % 15 == 0) px_phase(80, 1'b0);
    end
    fetch(50, -1);
    px_phase(120, 1'b0);
    fetch(-1, 30);
    repeat (4) @(posedge clk);
    #1;
    px_phase(60, 1'b0);
    rd_sig = 1'b1;
    for (int c = 0; c < W; c++) aq.push_back(15'(row_m * W + c));
    @(posedge clk); #1;
    rd_sig = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rd_sig = 1'b1;
    @(posedge clk); #1;
    rd_sig = 1'b0;
    chk("ovr_pre_abort", 32'(o_ovr), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    state = 8'h02;
    @(posedge clk);
    aq.delete();
    #1;
    chk("abort_rden", 32'(o_rden), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_ovr", 32'(o_ovr), 32'd0);
    chk("abort_und", 32'(o_und), 32'd0);
    ovr_m = 0; und_m = 0; row_m = 0; buf_row = -1;
    repeat (5) @(posedge clk);
    #1;
    rd_sig = 1'b1;
    @(posedge clk); #1;
    rd_sig = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    state = 8'h03;
    @(posedge clk); #1;
    fetch(-1, -1);
    px_phase(100, 1'b0);
    fetch(-1, -1);
    rd_sig = 1'b1;
    for (int c = 0; c < W; c++) aq.push_back(15'(row_m * W + c));
    @(posedge clk); #1;
    rd_sig = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    aq.delete();
    #1;
    chk_reset_vals("async_rst");
    row_m = 0; buf_row = -1; ovr_m = 0; und_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(-1, -1);
    px_phase(100, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("pxq_drained", 32'(pxq.size()), 32'd0);
    chk("aq_drained", 32'(aq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
